// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: state encoding, sizes and S-memory interface widths
// used by both the key-scheduling and decrypt FSMs.
package rc4_pkg;

  localparam int unsigned S_SIZE    = 256;
  localparam int unsigned KEY_BYTES = 3;
  localparam int unsigned KEY_W     = 8 * KEY_BYTES;
  localparam int unsigned S_ADDR_W  = 8;
  localparam int unsigned S_DATA_W  = 8;
  localparam int unsigned KIDX_W    = 2;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    RD_I,
    GET_I,
    RD_J,
    GET_J,
    WR_I,
    WR_J,
    DONE
  } state_t;

endpackage

// File: rtl/rc4_key_byte_sel.sv
// Picks key byte kidx from the key word, byte 0 being the most significant.
module rc4_key_byte_sel
  import rc4_pkg::*;
(
  input  logic [KEY_W-1:0]    key,
  input  logic [KIDX_W-1:0]   kidx,
  output logic [S_DATA_W-1:0] key_byte_c
);

  always_comb begin
    key_byte_c = '0;
    for (int unsigned k = 0; k < KEY_BYTES; k++) begin
      if (kidx == KIDX_W'(k)) key_byte_c = key[KEY_W-1-8*k -: 8];
    end
  end

endmodule

// File: rtl/rc4_ksa_fsm.sv
// RC4 key-scheduling FSM: fills S with the identity permutation, then runs the
// KSA swap loop over a synchronous-read S memory and pulses finish.
module rc4_ksa_fsm
  import rc4_pkg::*;
(
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic [KEY_W-1:0]    key,
  input  logic [S_DATA_W-1:0] s_q,
  output logic [S_ADDR_W-1:0] address,
  output logic [S_DATA_W-1:0] data,
  output logic                s_wren,
  output logic                finish
);

  localparam logic [S_ADDR_W-1:0] LAST_I   = S_ADDR_W'(S_SIZE - 1);
  localparam logic [KIDX_W-1:0]   LAST_KIX = KIDX_W'(KEY_BYTES - 1);

  state_t                state;
  logic [S_ADDR_W-1:0]   i;
  logic [S_ADDR_W-1:0]   j;
  logic [S_DATA_W-1:0]   si;
  logic [KIDX_W-1:0]     kidx;
  logic [S_DATA_W-1:0]   key_byte_c;
  logic [S_ADDR_W-1:0]   j_sum_c;

  rc4_key_byte_sel u_key_byte_sel (
    .key        (key),
    .kidx       (kidx),
    .key_byte_c (key_byte_c)
  );

  // 8-bit wrap is the mod-256 of the KSA index update.
  assign j_sum_c = j + s_q + key_byte_c;

  // Outputs are loaded on the edge entering a state, so they hold during it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      i       <= '0;
      j       <= '0;
      si      <= '0;
      kidx    <= '0;
      address <= '0;
      data    <= '0;
      s_wren  <= 1'b0;
      finish  <= 1'b0;
    end else begin
      finish <= 1'b0;
      s_wren <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= INIT;
            i       <= '0;
            address <= '0;
            data    <= '0;
            s_wren  <= 1'b1;
          end
        end
        INIT: begin
          if (i == LAST_I) begin
            state   <= RD_I;
            i       <= '0;
            j       <= '0;
            kidx    <= '0;
            address <= '0;
          end else begin
            i       <= i + S_ADDR_W'(1);
            address <= i + S_ADDR_W'(1);
            data    <= i + S_DATA_W'(1);
            s_wren  <= 1'b1;
          end
        end
        RD_I: state <= GET_I;
        GET_I: begin
          si      <= s_q;
          j       <= j_sum_c;
          address <= j_sum_c;
          state   <= RD_J;
        end
        RD_J: state <= GET_J;
        GET_J: begin
          // data register carries s[j] into the write of slot i
          address <= i;
          data    <= s_q;
          s_wren  <= 1'b1;
          state   <= WR_I;
        end
        WR_I: begin
          address <= j;
          data    <= si;
          s_wren  <= 1'b1;
          state   <= WR_J;
        end
        WR_J: begin
          if (i == LAST_I) begin
            finish <= 1'b1;
            state  <= DONE;
          end else begin
            i       <= i + S_ADDR_W'(1);
            address <= i + S_ADDR_W'(1);
            kidx    <= (kidx == LAST_KIX) ? '0 : kidx + KIDX_W'(1);
            state   <= RD_I;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_ksa_fsm.sv
// Scoreboard bench for rc4_ksa_fsm: expected S writes and finish cycles are
// queued at stimulus time and checked by an independent monitor process.
module tb_rc4_ksa_fsm;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [23:0] key;
  logic [7:0]  s_q;
  logic [7:0]  address;
  logic [7:0]  data;
  logic        s_wren;
  logic        finish;

  rc4_ksa_fsm dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .key     (key),
    .s_q     (s_q),
    .address (address),
    .data    (data),
    .s_wren  (s_wren),
    .finish  (finish)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Synchronous-read S memory, read-before-write.
  logic [7:0] mem [256];
  always @(posedge clock) begin
    if (s_wren) mem[address] <= data;
    s_q <= mem[address];
  end

  logic [15:0] wq[$];
  int          fq[$];
  logic [15:0] wlog[$];
  logic [7:0]  exp_s [256];
  int          checks = 0;
  int          errors = 0;
  int          fin_seen = 0;
  int          last_fin = 0;

  // Monitor: every presented write or finish pulse pops one expectation.
  initial begin
    logic [15:0] ew;
    int          ef;
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (s_wren) begin
          wlog.push_back({address, data});
          checks++;
          if (wq.size() == 0) begin
            errors++;
            $display("FAIL stray_write: got addr=%02h data=%02h at cyc %0d, required none", address, data, cyc);
          end else begin
            ew = wq.pop_front();
            if ({address, data} !== ew) begin
              errors++;
              $display("FAIL s_write: got addr=%02h data=%02h, required addr=%02h data=%02h (cyc %0d)",
                       address, data, ew[15:8], ew[7:0], cyc);
            end
          end
        end
        if (finish) begin
          fin_seen++;
          last_fin = cyc;
          checks++;
          if (fq.size() == 0) begin
            errors++;
            $display("FAIL stray_finish: got finish at cyc %0d, required none", cyc);
          end else begin
            ef = fq.pop_front();
            if (cyc != ef) begin
              errors++;
              $display("FAIL finish_cycle: got cyc %0d, required cyc %0d", cyc, ef);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Behavioural RC4 KSA producing the expected write stream and final image.
  task automatic push_run(input logic [23:0] k, input int sc);
    logic [7:0] s [256];
    logic [7:0] jj;
    logic [7:0] t;
    for (int n = 0; n < 256; n++) begin
      s[n] = 8'(n);
      wq.push_back({8'(n), 8'(n)});
    end
    jj = 8'd0;
    for (int n = 0; n < 256; n++) begin
      jj = jj + s[n] + k[23-8*(n%3) -: 8];
      wq.push_back({8'(n), s[jj]});
      wq.push_back({jj, s[n]});
      t = s[n]; s[n] = s[jj]; s[jj] = t;
    end
    for (int n = 0; n < 256; n++) exp_s[n] = s[n];
    fq.push_back(sc + 1792);
  endtask

  task automatic start_run(input logic [23:0] k, output int sc);
    wlog.delete();
    @(negedge clock);
    key = k;
    sc  = cyc + 1;
    push_run(k, sc);
    start = 1'b1;
    @(negedge clock);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_finish(input bit extra, input int sc);
    int target;
    target = fin_seen + 1;
    for (int c = 2; c < 2100 && fin_seen < target; c++) begin
      start = (extra && (c == 100 || c == 1000)) ? 1'b1 : 1'b0;
      @(negedge clock);
    end
    start = 1'b0;
    chk("finish_seen", fin_seen, target);
    chk("finish_latency", last_fin - sc + 1, 1793);
  endtask

  task automatic post_checks();
    int bad;
    int first;
    repeat (12) @(negedge clock);
    chk("write_queue_drained", wq.size(), 0);
    chk("finish_queue_drained", fq.size(), 0);
    bad = 0;
    first = -1;
    for (int n = 0; n < 256; n++) begin
      if (mem[n] !== exp_s[n]) begin
        bad++;
        if (first < 0) first = n;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL s_image: got %0d wrong bytes (first at %0d), required 0", bad, first);
    end
  endtask

  function automatic int log_at(input int idx);
    if (idx < wlog.size()) return int'(wlog[idx]);
    return -1;
  endfunction

  initial begin
    int sc;
    reset_n = 1'b0;
    start   = 1'b0;
    key     = 24'h0;
    #1;
    chk("reset_address", int'(address), 0);
    chk("reset_data", int'(data), 0);
    chk("reset_s_wren", int'(s_wren), 0);
    chk("reset_finish", int'(finish), 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // Identity fill order, single run from a 2-cycle start.
    start_run(24'h0a0b0c, sc);
    wait_finish(1'b0, sc);
    post_checks();
    chk("t1_first_init", log_at(0), 16'h0000);
    chk("t1_last_init", log_at(255), 16'hffff);
    chk("t1_write_count", wlog.size(), 768);

    // First swap with key 010203: j = 1.
    start_run(24'h010203, sc);
    wait_finish(1'b0, sc);
    post_checks();
    chk("t2_swap0_wr_i", log_at(256), 16'h0001);
    chk("t2_swap0_wr_j", log_at(257), 16'h0100);

    // All-zero key: self-swaps at i=0,1 then i=2 with j=3.
    start_run(24'h000000, sc);
    wait_finish(1'b0, sc);
    post_checks();
    chk("t3_i0_wr_i", log_at(256), 16'h0000);
    chk("t3_i0_wr_j", log_at(257), 16'h0000);
    chk("t3_i1_wr_i", log_at(258), 16'h0101);
    chk("t3_i1_wr_j", log_at(259), 16'h0101);
    chk("t3_i2_wr_i", log_at(260), 16'h0203);
    chk("t3_i2_wr_j", log_at(261), 16'h0302);

    // Latency and full image.
    start_run(24'h000249, sc);
    wait_finish(1'b0, sc);
    post_checks();

    // Stray start pulses during INIT and the swap loop are ignored.
    start_run(24'h000249, sc);
    wait_finish(1'b1, sc);
    post_checks();

    // Asynchronous reset mid-loop, then a clean rerun.
    start_run(24'h13579b, sc);
    repeat (897) @(negedge clock);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_address", int'(address), 0);
    chk("midrst_data", int'(data), 0);
    chk("midrst_s_wren", int'(s_wren), 0);
    chk("midrst_finish", int'(finish), 0);
    wq.delete();
    fq.delete();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    start_run(24'h13579b, sc);
    wait_finish(1'b0, sc);
    post_checks();
    chk("t6_write_count", wlog.size(), 768);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
